divu_sequencer: RTL and testbench
=================================

# divu_sequencer

Multicycle unsigned-divide sequencer for the MIPS pipeline's DIVU instruction. It time-shares the 32-bit ALU in subtract mode to run a restoring shift/subtract division, one quotient bit per cycle. It sits beside the EX stage and returns quotient (LO) and remainder (HI) with a start/busy/done handshake. It owns the ALU only while `alu_req` is high.

## Interface

- `WIDTH`, 32, operand/result width; the iteration count equals `WIDTH`.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a divide; sampled only in IDLE.
- `flush` in 1: abort the in-flight divide (pipeline flush).
- `dividend` in WIDTH: captured when start is accepted.
- `divisor` in WIDTH: captured when start is accepted.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse; results are valid from this cycle.
- `quotient` out WIDTH: LO value; held until the next completion.
- `remainder` out WIDTH: HI value; held until the next completion.
- `div0` out 1: divisor-zero flag. Present only with `DIVU_DIV0_EN`.
- `alu_req` out 1: high in RUN; the EX mux gives the ALU to this block.
- `alu_ctrl` out 4: driven to SUB (4'b0110) while `alu_req` is high; otherwise AND (4'b0000).
- `alu_a` out WIDTH: shifted partial remainder.
- `alu_b` out WIDTH: latched divisor.
- `alu_result` in WIDTH: ALU difference.
- `alu_cout` in 1: ALU carry-out; 1 means no borrow.

## Operation

- States are IDLE, RUN and DONE. The encoding is 2-bit: 00, 01, 10.
- **IDLE → RUN** on `start`:
  - latch the divisor;
  - rem ← 0, quo ← dividend;
  - cnt ← WIDTH-1.
- **RUN, each cycle:**
  - msb = rem[WIDTH-1];
  - `alu_a` = {rem[WIDTH-2:0], quo[WIDTH-1]};
  - take = msb | `alu_cout` (33-bit compare without a 33-bit ALU);
  - rem ← take ? `alu_result` : `alu_a`;
  - quo ← {quo[WIDTH-2:0], take};
  - cnt decrements.
- **RUN → DONE** after the iteration in which cnt == 0. On that edge `quotient`/`remainder` load from the final quo/rem.
- **DONE → IDLE** unconditionally after one cycle.
- **`start` outside IDLE** is ignored: no queueing, no error.
- **`flush` in RUN:**
  - next state IDLE;
  - no `done`;
  - `quotient`/`remainder` keep their previous values.
- **`flush` in IDLE or DONE** has no effect. If `flush` and `start` are both high in IDLE, `flush` wins and nothing starts.
- **Divisor zero without the macro:** the natural result is quotient = all-ones, remainder = dividend.
- **Reset, including mid-operation:**
  - state IDLE;
  - `busy`/`done`/`alu_req`/`div0` = 0;
  - `quotient`/`remainder` = 0;
  - `alu_ctrl` = 4'b0000;
  - work registers = 0.

## Timing

- Start is accepted at edge E0. RUN spans cycles 1..WIDTH, and `done` is high in cycle WIDTH+1 (cycle 33 for the default).
- Back-to-back divides: the earliest next `start` is accepted in the cycle after `done`. Total is WIDTH+2 cycles per divide.
- All outputs are registered or decoded from state only. There is no combinational path from `start` to `busy`: `busy` rises the cycle after acceptance.
- The ALU path `alu_a` → `alu_result`/`alu_cout` → rem/quo is the single combinational loop through the external ALU, within one cycle.

## Configuration

- `DIVU_DIV0_EN` defined:
  - divisor == 0 at start goes IDLE → DONE directly, skipping RUN;
  - `done` is high in cycle 1;
  - `div0` = 1 with `done`; quotient = all-ones, remainder = dividend;
  - `div0` clears when the next start is accepted.
- `DIVU_DIV0_EN` undefined:
  - no `div0` port;
  - divisor zero runs the full WIDTH iterations and yields the same values naturally.

## Structure

- Shared package `divu_pkg` holds:
  - the ALU op constants, consistent with the ALU slices: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, SLL 0011, DIVU 0100, BNE 0101;
  - the state encoding;
  - `WIDTH` default.
- One sub-module, `divu_step`: combinational single iteration. Inputs are rem, quo msb, `alu_result` and `alu_cout`; outputs are next rem, next quo and `alu_a`. The sequencer keeps the FSM, counter and output registers.

## Test plan

- 100 / 7 → `done` in cycle 33; quotient = 14, remainder = 2; `alu_ctrl` = 0110 throughout RUN.
- 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0. Also 0x80000000 / 0xFFFFFFFF → quotient 0, remainder 0x80000000, which exercises the msb=1 take path.
- 5 / 0 → quotient 0xFFFFFFFF, remainder 5:
  - without the macro: `done` in cycle 33;
  - with `DIVU_DIV0_EN`: `done` and `div0` in cycle 1.
- `start` pulsed in cycles 5 and 33 of a busy divide → ignored; a single `done`; results match the first operands.
- `flush` in cycle 10 → IDLE next cycle, no `done`, prior results unchanged; a new `start` then completes correctly.
- `rst_n` low in cycle 20 → immediate IDLE, all outputs 0; a divide after release (1000 / 3 → 333 r 1) is correct.

Source files
------------

// File: rtl/divu_pkg.sv
// Shared constants for the DIVU sequencer: ALU op codes, FSM encoding and default width.
package divu_pkg;

  localparam int DIVU_WIDTH = 32;

  // ALU control codes, matching the EX-stage ALU slices.
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_DIVU = 4'b0100;
  localparam logic [3:0] ALU_BNE  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // The shared ALU is parked in AND whenever this block does not own it.
  function automatic logic [3:0] alu_ctrl_for(input logic own);
    return own ? ALU_SUB : ALU_AND;
  endfunction

endpackage

// File: rtl/divu_if.sv
// Request/response bundle between the EX stage (master) and the DIVU sequencer (slave).
// Optional div0 flag appears only when DIVU_DIV0_EN is defined.
interface divu_if #(parameter int WIDTH = divu_pkg::DIVU_WIDTH);

  // Handshake: start is sampled only while busy is low; busy rises the cycle
  // after acceptance, done pulses one cycle with quotient/remainder valid from
  // that cycle and held until the next completion. flush aborts a running divide.
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIVU_DIV0_EN
  logic             div0;

  modport master (
    output start, flush, dividend, divisor,
    input  busy, done, quotient, remainder, div0
  );

  modport slave (
    input  start, flush, dividend, divisor,
    output busy, done, quotient, remainder, div0
  );
`else
  modport master (
    output start, flush, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, flush, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif

endinterface

// File: rtl/divu_step.sv
// One restoring-division iteration, with the subtract done by the external shared ALU.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt,
  output logic [WIDTH-1:0] alu_a
);

  logic take;

  assign alu_a = {rem[WIDTH-2:0], quo[WIDTH-1]};

  // The shifted remainder is really WIDTH+1 bits; a set msb means it already
  // exceeds any divisor, so the subtract is taken regardless of the borrow.
  assign take    = rem[WIDTH-1] | alu_cout;
  assign rem_nxt = take ? alu_result : alu_a;
  assign quo_nxt = {quo[WIDTH-2:0], take};

endmodule

// File: rtl/divu_sequencer.sv
// Multicycle unsigned divider for DIVU, borrowing the EX ALU in subtract mode.
// Define DIVU_DIV0_EN to short-circuit zero divisors and expose the div0 flag.
module divu_sequencer
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  divu_if.slave            bus,
  output logic             alu_req,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             accept;

  assign accept = (state == ST_IDLE) && bus.start && !bus.flush;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem),
    .quo        (quo),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .rem_nxt    (rem_nxt),
    .quo_nxt    (quo_nxt),
    .alu_a      (alu_a)
  );

`ifdef DIVU_DIV0_EN
  logic div0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div0_q <= 1'b0;
    end else if (accept) begin
      div0_q <= (bus.divisor == '0);
    end
  end

  assign bus.div0 = div0_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dvsr  <= bus.divisor;
            rem   <= '0;
            quo   <= bus.dividend;
            cnt   <= CNT_W'(WIDTH - 1);
            state <= ST_RUN;
`ifdef DIVU_DIV0_EN
            if (bus.divisor == '0) begin
              state       <= ST_DONE;
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
            end
`endif
          end
        end
        ST_RUN: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - 1'b1;
            // Results publish on the same edge that leaves RUN.
            if (cnt == '0) begin
              state       <= ST_DONE;
              quotient_q  <= quo_nxt;
              remainder_q <= rem_nxt;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == ST_RUN) || (state == ST_DONE);
  assign bus.done      = (state == ST_DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign alu_req       = (state == ST_RUN);
  assign alu_ctrl      = alu_ctrl_for(state == ST_RUN);
  assign alu_b         = dvsr;
  assign dbg_state     = state;

endmodule

// File: tb/tb_divu_sequencer.sv
// Directed bench for divu_sequencer: the bench plays the shared ALU and keeps a
// cycle-level arithmetic model of the expected handshake and results.
module tb_divu_sequencer;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divu_if bus ();
  logic         alu_req;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         alu_cout;
  logic [1:0]   dbg_state;

  divu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_req    (alu_req),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .dbg_state  (dbg_state)
  );

  // Shared ALU stand-in: SUB gives a - b with carry = no borrow; anything else ANDs.
  always_comb begin
    alu_result = alu_a & alu_b;
    alu_cout   = 1'b0;
    if (alu_ctrl == 4'b0110) begin
      {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // m_age: 0 idle, 1..W cycles into the iteration window, W+1 the result cycle.
  int           m_age;
  logic [W-1:0] m_a, m_b, m_q, m_r;
`ifdef DIVU_DIV0_EN
  logic         m_div0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= 0;
      m_a <= '0; m_b <= '0; m_q <= '0; m_r <= '0;
`ifdef DIVU_DIV0_EN
      m_div0 <= 1'b0;
`endif
    end else if (m_age == 0) begin
      if (bus.start && !bus.flush) begin
        m_a   <= bus.dividend;
        m_b   <= bus.divisor;
        m_age <= 1;
`ifdef DIVU_DIV0_EN
        m_div0 <= (bus.divisor == 0);
        if (bus.divisor == 0) begin
          m_age <= W + 1;
          m_q   <= '1;
          m_r   <= bus.dividend;
        end
`endif
      end
    end else if (m_age <= W) begin
      if (bus.flush) m_age <= 0;
      else if (m_age == W) begin
        m_age <= W + 1;
        m_q   <= ref_q(m_a, m_b);
        m_r   <= ref_r(m_a, m_b);
      end else m_age <= m_age + 1;
    end else begin
      m_age <= 0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",      W'(bus.busy),  W'(m_age != 0));
      chk("done",      W'(bus.done),  W'(m_age == W + 1));
      chk("alu_req",   W'(alu_req),   W'(m_age >= 1 && m_age <= W));
      chk("alu_ctrl",  W'(alu_ctrl),  (m_age >= 1 && m_age <= W) ? W'(4'b0110) : W'(4'b0000));
      chk("quotient",  bus.quotient,  m_q);
      chk("remainder", bus.remainder, m_r);
      if (m_age >= 1 && m_age <= W) chk("alu_b", alu_b, m_b);
`ifdef DIVU_DIV0_EN
      chk("div0",      W'(bus.div0),  W'(m_div0));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Called at #1 after a rising edge with the DUT idle; returns one cycle after done.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input int lat);
    int cyc;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_cycle", W'(cyc), W'(lat));
    chk("lit_quotient", bus.quotient, eq);
    chk("lit_remainder", bus.remainder, er);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ndone;
    int done_cyc;
    bus.start = 1'b0; bus.flush = 1'b0; bus.dividend = '0; bus.divisor = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_quotient", bus.quotient, '0);
    chk("rst_alu_ctrl", W'(alu_ctrl), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div(32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
`ifdef DIVU_DIV0_EN
    run_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
    chk("lit_div0", W'(bus.div0), W'(1));
`else
    run_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 33);
`endif

    // start pulses during RUN (cycle 5) and DONE (cycle 33) must be ignored
    bus.start = 1'b1; bus.dividend = 32'd12345; bus.divisor = 32'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0; done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done) begin ndone++; done_cyc = c; end
      if (c == 5 || c == 33) begin
        bus.start = 1'b1; bus.dividend = 32'd999; bus.divisor = 32'd2;
      end else bus.start = 1'b0;
      @(posedge clk); #1;
    end
    chk("ignore_ndone", W'(ndone), W'(1));
    chk("ignore_done_cycle", W'(done_cyc), W'(33));
    chk("ignore_quotient", bus.quotient, 32'd1234);
    chk("ignore_remainder", bus.remainder, 32'd5);

    // flush in cycle 10: back to idle, no done, prior results kept
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done) ndone++;
      if (c == 11) chk("flush_busy", W'(bus.busy), '0);
      bus.flush = (c == 10);
      @(posedge clk); #1;
    end
    chk("flush_ndone", W'(ndone), '0);
    chk("flush_quotient", bus.quotient, 32'd1234);
    chk("flush_remainder", bus.remainder, 32'd5);

    // flush beats start in idle
    bus.start = 1'b1; bus.flush = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_busy", W'(bus.busy), '0);
    run_div(32'd77, 32'd8, 32'd9, 32'd5, 33);

    // asynchronous reset in cycle 20
    bus.start = 1'b1; bus.dividend = 32'd40; bus.divisor = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", W'(bus.busy), '0);
    chk("midrst_alu_req", W'(alu_req), '0);
    chk("midrst_alu_ctrl", W'(alu_ctrl), '0);
    chk("midrst_quotient", bus.quotient, '0);
    chk("midrst_remainder", bus.remainder, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_div(32'd1000, 32'd3, 32'd333, 32'd1, 33);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
